// File: rtl/debug_reg_streamer.sv
// debug_reg_streamer
//   Snapshots the packed architectural register image on Trigger and streams it
//   out one byte per accepted transfer over a valid/ready link:
//   SYNC_BYTE header, then reg 0..N-1, each least-significant byte first.
//   The core is never stalled; triggers arriving mid-frame are counted and dropped.
//   Optional build macro: DEBUG_STREAM_CHECKSUM_EN appends one XOR checksum byte
//   covering all data bytes (header excluded).
module debug_reg_streamer #(
    parameter int          A         = 3,
    parameter int          L         = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [L*(1<<A)-1:0]   DebugData,
    input  logic                  Trigger,
    input  logic                  OutReady,
    output logic [7:0]            OutData,
    output logic                  OutValid,
    output logic                  Busy,
    output logic                  FrameDone,
    output logic [7:0]            DropCount
);

    // Image geometry: total bits, data bytes per frame and byte-index width.
    localparam int W  = L * (1 << A);
    localparam int NB = W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
`ifdef DEBUG_STREAM_CHECKSUM_EN
        ST_DATA   = 2'd2,
        ST_CSUM   = 2'd3
`else
        ST_DATA   = 2'd2
`endif
    } state_t;

    // Byte k of the image is bits [8k+7:8k]; since registers are packed in
    // ascending order this is exactly "reg 0 first, LSB first".
    function automatic logic [7:0] selectByte(input logic [W-1:0] img,
                                              input logic [IW-1:0] idx);
        logic [W-1:0] shifted;
        shifted = img >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

`ifdef DEBUG_STREAM_CHECKSUM_EN
    // Byte-wise XOR parity over the whole snapshot.
    function automatic logic [7:0] xorBytes(input logic [W-1:0] img);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NB; i++) begin
            acc = acc ^ img[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    // Current-state registers
    state_t          state_r;
    logic [W-1:0]    snapshot_r;
    logic [IW-1:0]   byteIdx_r;
    logic [7:0]      outData_r;
    logic            outValid_r;
    logic            busy_r;
    logic            frameDone_r;
    logic [7:0]      dropCount_r;

    // Next-state values
    state_t          stateNext_s;
    logic [W-1:0]    snapshotNext_s;
    logic [IW-1:0]   byteIdxNext_s;
    logic [7:0]      outDataNext_s;
    logic            outValidNext_s;
    logic            busyNext_s;
    logic            frameDoneNext_s;
    logic [7:0]      dropCountNext_s;

    logic            accept_s;
    logic [IW-1:0]   byteIdxInc_s;

    assign accept_s     = outValid_r & OutReady;
    assign byteIdxInc_s = byteIdx_r + IW'(1);

    // Frame sequencer: next state, snapshot capture and the next output byte.
    always_comb begin
        stateNext_s     = state_r;
        snapshotNext_s  = snapshot_r;
        byteIdxNext_s   = byteIdx_r;
        outDataNext_s   = outData_r;
        outValidNext_s  = outValid_r;
        busyNext_s      = busy_r;
        frameDoneNext_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (Trigger) begin
                    snapshotNext_s = DebugData;
                    stateNext_s    = ST_HEADER;
                    byteIdxNext_s  = '0;
                    outDataNext_s  = SYNC_BYTE;
                    outValidNext_s = 1'b1;
                    busyNext_s     = 1'b1;
                end else begin
                    outValidNext_s = 1'b0;
                    busyNext_s     = 1'b0;
                end
            end

            ST_HEADER: begin
                if (accept_s) begin
                    stateNext_s   = ST_DATA;
                    byteIdxNext_s = '0;
                    outDataNext_s = selectByte(snapshot_r, '0);
                end else begin
                    stateNext_s   = ST_HEADER;
                end
            end

            ST_DATA: begin
                if (accept_s) begin
                    if (byteIdx_r == LAST_IDX) begin
`ifdef DEBUG_STREAM_CHECKSUM_EN
                        stateNext_s    = ST_CSUM;
                        outDataNext_s  = xorBytes(snapshot_r);
`else
                        stateNext_s     = ST_IDLE;
                        outDataNext_s   = 8'h00;
                        outValidNext_s  = 1'b0;
                        busyNext_s      = 1'b0;
                        frameDoneNext_s = 1'b1;
`endif
                    end else begin
                        byteIdxNext_s = byteIdxInc_s;
                        outDataNext_s = selectByte(snapshot_r, byteIdxInc_s);
                    end
                end else begin
                    stateNext_s = ST_DATA;
                end
            end

`ifdef DEBUG_STREAM_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_s) begin
                    stateNext_s     = ST_IDLE;
                    outDataNext_s   = 8'h00;
                    outValidNext_s  = 1'b0;
                    busyNext_s      = 1'b0;
                    frameDoneNext_s = 1'b1;
                end else begin
                    stateNext_s = ST_CSUM;
                end
            end
`endif

            default: begin
                stateNext_s    = ST_IDLE;
                outValidNext_s = 1'b0;
                busyNext_s     = 1'b0;
            end
        endcase
    end

    // Dropped-trigger counter: any Trigger seen while a frame is in flight,
    // saturating so a stuck trigger cannot wrap it back to a small value.
    always_comb begin
        dropCountNext_s = dropCount_r;
        if (busy_r && Trigger && (dropCount_r != 8'hFF)) begin
            dropCountNext_s = dropCount_r + 8'd1;
        end else begin
            dropCountNext_s = dropCount_r;
        end
    end

    // State and output registers; Reset aborts any frame immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            snapshot_r  <= '0;
            byteIdx_r   <= '0;
            outData_r   <= 8'h00;
            outValid_r  <= 1'b0;
            busy_r      <= 1'b0;
            frameDone_r <= 1'b0;
            dropCount_r <= 8'h00;
        end else begin
            state_r     <= stateNext_s;
            snapshot_r  <= snapshotNext_s;
            byteIdx_r   <= byteIdxNext_s;
            outData_r   <= outDataNext_s;
            outValid_r  <= outValidNext_s;
            busy_r      <= busyNext_s;
            frameDone_r <= frameDoneNext_s;
            dropCount_r <= dropCountNext_s;
        end
    end

    assign OutData   = outData_r;
    assign OutValid  = outValid_r;
    assign Busy      = busy_r;
    assign FrameDone = frameDone_r;
    assign DropCount = dropCount_r;

endmodule

// File: tb/tb_debug_reg_streamer.sv
// tb_debug_reg_streamer
//   Self-checking bench for debug_reg_streamer. A frame-level model holds the
//   queue of bytes still owed to the sink; outputs are compared on every cycle.
//   Honours DEBUG_STREAM_CHECKSUM_EN for the expected frame contents.
module tb_debug_reg_streamer;

    localparam int A  = 3;
    localparam int L  = 16;
    localparam int NR = 1 << A;
    localparam int W  = L * NR;
    localparam int NB = W / 8;
`ifdef DEBUG_STREAM_CHECKSUM_EN
    localparam int FRAME_LEN = NB + 2;
`else
    localparam int FRAME_LEN = NB + 1;
`endif

    logic          Clk;
    logic          Reset;
    logic [W-1:0]  DebugData;
    logic          Trigger;
    logic          OutReady;
    logic [7:0]    OutData;
    logic          OutValid;
    logic          Busy;
    logic          FrameDone;
    logic [7:0]    DropCount;

    int checks;
    int errors;
    bit checkEn;

    // Model state: bytes still to be delivered, expected FrameDone, expected drops
    logic [7:0] mq[$];
    logic       mFd;
    int         mDrop;

    // Bytes actually accepted from the DUT
    logic [7:0] acceptedQ[$];

    int readyMode;   // 0 always ready, 1 toggle, 2 random, 3 never
    bit readyPhase;

    debug_reg_streamer #(.A(A), .L(L), .SYNC_BYTE(8'hA5)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .DebugData (DebugData),
        .Trigger   (Trigger),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .Busy      (Busy),
        .FrameDone (FrameDone),
        .DropCount (DropCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xorAll(input logic [W-1:0] img);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NB; i++) acc = acc ^ img[8*i +: 8];
        return acc;
    endfunction

    function automatic logic [W-1:0] mkPattern(input logic [15:0] base, input logic [15:0] step);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[16*i +: 16] = base + step * 16'(i);
        return v;
    endfunction

    // Reference model: a frame is a byte list built at the capture edge and
    // popped one element per accepted transfer.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mq.delete();
            mFd   <= 1'b0;
            mDrop <= 0;
        end else if (mq.size() > 0) begin
            mDrop <= (Trigger && mDrop < 255) ? mDrop + 1 : mDrop;
            mFd   <= OutReady && (mq.size() == 1);
            if (OutReady) void'(mq.pop_front());
        end else begin
            mFd <= 1'b0;
            if (Trigger) begin
                mq.push_back(8'hA5);
                for (int i = 0; i < NB; i++) mq.push_back(DebugData[8*i +: 8]);
`ifdef DEBUG_STREAM_CHECKSUM_EN
                mq.push_back(xorAll(DebugData));
`endif
            end
        end
    end

    // Record every byte the sink takes
    always @(posedge Clk) begin
        if (!Reset && OutValid === 1'b1 && OutReady) acceptedQ.push_back(OutData);
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge Clk) begin
        if (checkEn && !Reset) begin
            chk("cmp_valid", {31'b0, OutValid}, {31'b0, (mq.size() > 0)});
            chk("cmp_busy", {31'b0, Busy}, {31'b0, (mq.size() > 0)});
            chk("cmp_done", {31'b0, FrameDone}, {31'b0, mFd});
            chk("cmp_drops", {24'b0, DropCount}, 32'(mDrop));
            if (mq.size() > 0) chk("cmp_data", {24'b0, OutData}, {24'b0, mq[0]});
        end
    end

    // Drive inputs for one cycle (called at a negedge), then advance to the next negedge
    task automatic cycle(input logic trig);
        Trigger = trig;
        case (readyMode)
            0: OutReady = 1'b1;
            1: begin OutReady = readyPhase; readyPhase = ~readyPhase; end
            2: OutReady = ($urandom_range(0, 3) != 0);
            default: OutReady = 1'b0;
        endcase
        @(negedge Clk);
    endtask

    task automatic runUntilDone(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit && FrameDone !== 1'b1) begin
            cycle(1'b0);
            cyc++;
        end
        if (FrameDone !== 1'b1) chk("frame_timeout", 32'(cyc), 32'(limit + 1));
    endtask

    task automatic resetDut();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    int cyc;

    initial begin
        checks = 0; errors = 0; checkEn = 1'b0;
        readyMode = 0; readyPhase = 1'b0;
        Reset = 1'b0; Trigger = 1'b0; OutReady = 1'b0; DebugData = '0;
        #2 Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checkEn = 1'b1;

        // Reset values
        chk("rst_data", {24'b0, OutData}, 32'h0);
        chk("rst_valid", {31'b0, OutValid}, 32'h0);
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        chk("rst_done", {31'b0, FrameDone}, 32'h0);
        chk("rst_drops", {24'b0, DropCount}, 32'h0);

        // Test 1: reg i = 16'h1100+i, ready always high
        DebugData = mkPattern(16'h1100, 16'h0001);
        readyMode = 0;
        acceptedQ.delete();
        cycle(1'b1);
        runUntilDone(100, cyc);
        chk("t1_cycles", 32'(cyc), 32'(FRAME_LEN));
        chk("t1_len", 32'(acceptedQ.size()), 32'(FRAME_LEN));
        chk("t1_b0", {24'b0, acceptedQ[0]}, 32'hA5);
        chk("t1_b1", {24'b0, acceptedQ[1]}, 32'h00);
        chk("t1_b2", {24'b0, acceptedQ[2]}, 32'h11);
        chk("t1_b3", {24'b0, acceptedQ[3]}, 32'h01);
        chk("t1_b15", {24'b0, acceptedQ[15]}, 32'h07);
        chk("t1_b16", {24'b0, acceptedQ[16]}, 32'h11);
`ifdef DEBUG_STREAM_CHECKSUM_EN
        chk("t6_csum_a", {24'b0, acceptedQ[17]}, 32'h00);
`endif

        // Test 2: ready toggling, first data-phase cycle ready
        readyMode = 1; readyPhase = 1'b0;
        acceptedQ.delete();
        cycle(1'b1);
        runUntilDone(200, cyc);
        chk("t2_cycles", 32'(cyc), 32'(2 * FRAME_LEN - 1));
        chk("t2_len", 32'(acceptedQ.size()), 32'(FRAME_LEN));
        chk("t2_b1", {24'b0, acceptedQ[1]}, 32'h00);
        chk("t2_b16", {24'b0, acceptedQ[16]}, 32'h11);

        // Test 3: DebugData overwritten right after capture
        readyMode = 0;
        DebugData = mkPattern(16'h2200, 16'h0003);
        acceptedQ.delete();
        cycle(1'b1);
        DebugData = {W{1'b1}};
        runUntilDone(100, cyc);
        chk("t3_b1", {24'b0, acceptedQ[1]}, 32'h00);
        chk("t3_b2", {24'b0, acceptedQ[2]}, 32'h22);
        chk("t3_b3", {24'b0, acceptedQ[3]}, 32'h03);
        chk("t3_b15", {24'b0, acceptedQ[15]}, 32'h15);

        // Test 4: trigger held during a frame, then saturation
        resetDut();
        DebugData = mkPattern(16'h1100, 16'h0001);
        acceptedQ.delete();
        cycle(1'b1);
        repeat (5) cycle(1'b1);
        runUntilDone(100, cyc);
        chk("t4_drops5", {24'b0, DropCount}, 32'h5);
        repeat (5) cycle(1'b0);
        chk("t4_no_refire", {31'b0, OutValid}, 32'h0);
        chk("t4_len", 32'(acceptedQ.size()), 32'(FRAME_LEN));
        readyMode = 3;
        cycle(1'b1);
        repeat (300) cycle(1'b1);
        chk("t4_sat", {24'b0, DropCount}, 32'hFF);
        readyMode = 0;
        runUntilDone(100, cyc);

        // Test 5: reset during byte 6, then a fresh frame
        acceptedQ.delete();
        cycle(1'b1);
        repeat (6) cycle(1'b0);
        chk("t5_pre", 32'(acceptedQ.size()), 32'h6);
        #2 Reset = 1'b1;
        #1;
        chk("t5_valid_async", {31'b0, OutValid}, 32'h0);
        chk("t5_busy_async", {31'b0, Busy}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        chk("t5_drops_cleared", {24'b0, DropCount}, 32'h0);
        acceptedQ.delete();
        DebugData = mkPattern(16'h3300, 16'h0101);
        cycle(1'b1);
        runUntilDone(100, cyc);
        chk("t5_hdr", {24'b0, acceptedQ[0]}, 32'hA5);
        chk("t5_b2", {24'b0, acceptedQ[2]}, 32'h33);
        chk("t5_len", 32'(acceptedQ.size()), 32'(FRAME_LEN));

`ifdef DEBUG_STREAM_CHECKSUM_EN
        // Checksum pins
        DebugData = mkPattern(16'h00FF, 16'h0000);
        acceptedQ.delete();
        cycle(1'b1);
        runUntilDone(100, cyc);
        chk("t6_csum_b", {24'b0, acceptedQ[17]}, 32'h00);
        DebugData = '0;
        DebugData[15:0] = 16'h0001;
        acceptedQ.delete();
        cycle(1'b1);
        runUntilDone(100, cyc);
        chk("t6_csum_c", {24'b0, acceptedQ[17]}, 32'h01);
`endif

        // Randomized traffic: random data, random ready, sporadic triggers
        readyMode = 2;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 1) == 0)
                DebugData = {$urandom, $urandom, $urandom, $urandom};
            cycle($urandom_range(0, 24) == 0);
        end
        readyMode = 0;
        repeat (3 * FRAME_LEN) cycle(1'b0);
        chk("rand_idle", {31'b0, Busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
